// File: rtl/mem_fill_responder.sv
// Memory-side responder for the cache fill path: single-port word-addressed data memory
// with a fixed-latency read pipeline and an in-flight read counter.
module mem_fill_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [3:0]  rd_pending
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [15:0]        mem_q [Depth];
  logic [ADDR_W-1:0]  idx;
  logic               rd_accept;
  logic               wr_accept;
  logic [LATENCY-1:0] pipe_valid_q;
  logic [15:0]        pipe_data_q [LATENCY];
  logic [3:0]         rd_pending_q;
  logic [3:0]         rd_pending_d;

  // addr[0] selects a byte within the word and is ignored; upper bits alias.
  assign idx       = addr[ADDR_W:1];
  assign rd_accept = enable & ~wr;
  assign wr_accept = enable & wr;

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[idx] <= data_in;
    end
  end

  // Data in each stage only advances behind a valid entry, so the final stage (and
  // hence data_out) holds its last returned word across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_q <= '0;
      for (int k = 0; k < int'(LATENCY); k++) begin
        pipe_data_q[k] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= rd_accept;
      if (rd_accept) begin
        pipe_data_q[0] <= mem_q[idx];
      end
      for (int k = 1; k < int'(LATENCY); k++) begin
        pipe_valid_q[k] <= pipe_valid_q[k-1];
        if (pipe_valid_q[k-1]) begin
          pipe_data_q[k] <= pipe_data_q[k-1];
        end
      end
    end
  end

  assign data_valid = pipe_valid_q[LATENCY-1];
  assign data_out   = pipe_data_q[LATENCY-1];

  always_comb begin
    rd_pending_d = rd_pending_q;
    unique case ({rd_accept, data_valid})
      2'b10:   rd_pending_d = rd_pending_q + 4'd1;
      2'b01:   rd_pending_d = rd_pending_q - 4'd1;
      default: rd_pending_d = rd_pending_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
    end
  end

  assign rd_pending = rd_pending_q;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Bench for mem_fill_responder: three instances (LATENCY 4, 1, 8) share stimulus; a
// per-instance scoreboard queue holds expected read data and the edge it must appear after.
module tb_mem_fill_responder;

  typedef struct {
    int          due;
    logic [15:0] d;
  } exp_t;

  localparam int LAT [3] = '{4, 1, 8};

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] dout [3];
  logic        dv   [3];
  logic [3:0]  pend [3];

  exp_t        sbq  [3][$];
  logic [15:0] mdl  [1024];
  int          ec;
  int          n_cmp;
  int          n_err;

  mem_fill_responder #(.LATENCY(4), .ADDR_W(10)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(dout[0]), .data_valid(dv[0]), .rd_pending(pend[0])
  );
  mem_fill_responder #(.LATENCY(1), .ADDR_W(10)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(dout[1]), .data_valid(dv[1]), .rd_pending(pend[1])
  );
  mem_fill_responder #(.LATENCY(8), .ADDR_W(10)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(dout[2]), .data_valid(dv[2]), .rd_pending(pend[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ec <= ec + 1;

  function automatic int widx(input logic [15:0] a);
    return int'(a[10:1]);
  endfunction

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (pend[k] !== 4'(sbq[k].size())) begin
        n_err++;
        $display("FAIL rd_pending lat%0d @edge %0d: got %0d expected %0d",
                 LAT[k], ec, pend[k], sbq[k].size());
      end
      if (dv[k] === 1'b1) begin
        n_cmp++;
        if (sbq[k].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid lat%0d @edge %0d: got data_valid=1 expected 0",
                   LAT[k], ec);
        end else begin
          exp_t e;
          e = sbq[k].pop_front();
          if (dout[k] !== e.d || ec != e.due) begin
            n_err++;
            $display("FAIL read_data lat%0d: got %h @edge %0d expected %h @edge %0d",
                     LAT[k], dout[k], ec, e.d, e.due);
          end
        end
      end else if (sbq[k].size() != 0 && sbq[k][0].due <= ec) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_valid lat%0d @edge %0d: got data_valid=%b expected 1 data %h",
                 LAT[k], ec, dv[k], sbq[k][0].d);
        void'(sbq[k].pop_front());
      end
    end
  end

  // Presents one request for one cycle; returns 1 time unit after the accepting edge.
  task automatic drive(input logic en, input logic w, input logic [15:0] a,
                       input logic [15:0] d);
    exp_t e;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    if (en && !w) begin
      for (int k = 0; k < 3; k++) begin
        e.due = ec + LAT[k] - 1;
        e.d   = mdl[widx(a)];
        sbq[k].push_back(e);
      end
    end
    if (en && w) mdl[widx(a)] = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (dv[k] !== 1'b0 || dout[k] !== 16'h0000 || pend[k] !== 4'd0) begin
        n_err++;
        $display("FAIL reset_state lat%0d: got valid=%b data=%h pending=%0d expected 0/0000/0",
                 LAT[k], dv[k], dout[k], pend[k]);
      end
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_midflight;
    drive(1'b1, 1'b1, 16'h0040, 16'hBEEF);
    drive(1'b1, 1'b1, 16'h0042, 16'hCAFE);
    drive(1'b1, 1'b1, 16'h0044, 16'hF00D);
    drive(1'b1, 1'b0, 16'h0040, 16'h0);
    drive(1'b1, 1'b0, 16'h0042, 16'h0);
    drive(1'b1, 1'b0, 16'h0044, 16'h0);
    enable = 1'b0;
    rst_n  = 1'b0;
    for (int k = 0; k < 3; k++) sbq[k].delete();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (dv[k] !== 1'b0 || pend[k] !== 4'd0) begin
        n_err++;
        $display("FAIL midflight_reset lat%0d: got valid=%b pending=%0d expected 0/0",
                 LAT[k], dv[k], pend[k]);
      end
    end
    rst_n = 1'b1;
    idle(10);
    drive(1'b1, 1'b0, 16'h0040, 16'h0);
    drive(1'b1, 1'b0, 16'h0042, 16'h0);
    drive(1'b1, 1'b0, 16'h0044, 16'h0);
    idle(10);
  endtask

  task automatic test_single_read;
    int hits;
    int first;
    logic [15:0] got;
    hits  = 0;
    first = -1;
    got   = 16'h0;
    drive(1'b1, 1'b1, 16'h0010, 16'h1234);
    idle(3);
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    n_cmp++;
    if (pend[0] !== 4'd1) begin
      n_err++;
      $display("FAIL single_pending_start: got %0d expected 1", pend[0]);
    end
    for (int i = 1; i <= 6; i++) begin
      idle(1);
      if (dv[0] === 1'b1) begin
        hits++;
        first = i;
        got   = dout[0];
      end
      if (i == 4) begin
        n_cmp++;
        if (pend[0] !== 4'd0) begin
          n_err++;
          $display("FAIL single_pending_end: got %0d expected 0", pend[0]);
        end
      end
    end
    n_cmp++;
    if (hits != 1 || first != 3 || got !== 16'h1234) begin
      n_err++;
      $display("FAIL single_read: got %0d pulses at +%0d data %h expected 1 at +3 data 1234",
               hits, first, got);
    end
    idle(4);
  endtask

  task automatic test_burst;
    logic [3:0] peak [3];
    for (int k = 0; k < 3; k++) peak[k] = 4'd0;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'h0100 + 16'(2 * i), 16'h5A00 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'h0100 + 16'(2 * i), 16'h0);
      for (int k = 0; k < 3; k++) if (pend[k] > peak[k]) peak[k] = pend[k];
    end
    for (int i = 0; i < 10; i++) begin
      idle(1);
      for (int k = 0; k < 3; k++) if (pend[k] > peak[k]) peak[k] = pend[k];
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (int'(peak[k]) != LAT[k]) begin
        n_err++;
        $display("FAIL burst_peak lat%0d: got %0d expected %0d", LAT[k], peak[k], LAT[k]);
      end
    end
  endtask

  task automatic test_hazards;
    drive(1'b1, 1'b1, 16'h0020, 16'hAAAA);
    drive(1'b1, 1'b0, 16'h0020, 16'h0);
    drive(1'b1, 1'b0, 16'h0020, 16'h0);
    drive(1'b1, 1'b1, 16'h0020, 16'h5555);
    drive(1'b1, 1'b0, 16'h0020, 16'h0);
    idle(10);
  endtask

  task automatic test_bubbles_alias;
    drive(1'b1, 1'b1, 16'h0030, 16'h1111);
    drive(1'b1, 1'b1, 16'h0032, 16'h2222);
    drive(1'b1, 1'b0, 16'h0030, 16'h0);
    drive(1'b0, 1'bx, 16'hxxxx, 16'hxxxx);
    drive(1'b1, 1'b0, 16'h0032, 16'h0);
    idle(10);
    drive(1'b1, 1'b1, 16'h0002, 16'h7E57);
    drive(1'b1, 1'b0, 16'h0802, 16'h0);
    drive(1'b1, 1'b1, 16'hF806, 16'h0DD0);
    drive(1'b1, 1'b0, 16'h0006, 16'h0);
    idle(10);
  endtask

  task automatic test_odd_byte;
    drive(1'b1, 1'b1, 16'h0050, 16'h9ABC);
    drive(1'b1, 1'b0, 16'h0051, 16'h0);
    drive(1'b1, 1'b1, 16'h0053, 16'h4321);
    drive(1'b1, 1'b0, 16'h0052, 16'h0);
    drive(1'b1, 1'b0, 16'h0050, 16'h0);
    idle(10);
  endtask

  task automatic test_drain;
    idle(10);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (sbq[k].size() != 0 || pend[k] !== 4'd0) begin
        n_err++;
        $display("FAIL drain lat%0d: got %0d outstanding pending=%0d expected 0/0",
                 LAT[k], sbq[k].size(), pend[k]);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    ec      = 0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    wr      = 1'b0;
    addr    = 16'h0;
    data_in = 16'h0;
    test_reset();
    test_reset_midflight();
    test_single_read();
    test_burst();
    test_hazards();
    test_bubbles_alias();
    test_odd_byte();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
